// File: rtl/unidade_controle_quiz.sv
// Quiz game control unit: question sequencing, answer timing,
// replay handling and score keeping for a button-based quiz.
module unidade_controle_quiz #(
    parameter int N_RODADAS  = 8,
    parameter int N_BOTOES   = 4,
    parameter int T_MOSTRA   = 100,
    parameter int T_RESPOSTA = 500,
    parameter int MAX_VOLTAS = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic [N_BOTOES-1:0]            botoes,
    input  logic [N_BOTOES-1:0]            resposta_certa,
    input  logic                           volta,
    output logic [$clog2(N_RODADAS)-1:0]   endereco,
    output logic                           mostra_pergunta,
    output logic                           espera_jogada,
    output logic                           acertou,
    output logic                           errou,
    output logic                           timeout,
    output logic [$clog2(N_RODADAS+1)-1:0] pontos,
    output logic [N_BOTOES-1:0]            jogada_reg,
    output logic                           pronto,
    output logic [3:0]                     db_estado
);

    localparam int AW   = $clog2(N_RODADAS);
    localparam int PW   = $clog2(N_RODADAS + 1);
    localparam int TMAX = (T_MOSTRA > T_RESPOSTA) ? T_MOSTRA : T_RESPOSTA;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int VW   = (MAX_VOLTAS < 1) ? 1 : $clog2(MAX_VOLTAS + 1);

    localparam logic [AW-1:0] ULTIMA   = AW'(N_RODADAS - 1);
    localparam logic [PW-1:0] PTS_MAX  = PW'(N_RODADAS);
    localparam logic [TW-1:0] FIM_MOST = TW'(T_MOSTRA - 1);
    localparam logic [TW-1:0] FIM_RESP = TW'(T_RESPOSTA - 1);
    localparam logic [VW-1:0] VOLT_MAX = VW'(MAX_VOLTAS);

    typedef enum logic [3:0] {
        INICIAL         = 4'd0,
        INICIO_JOGO     = 4'd1,
        PROXIMA_RODADA  = 4'd3,
        MOSTRA_PERGUNTA = 4'd4,
        ESPERA_JOGADA   = 4'd7,
        COMPARA_JOGADA  = 4'd8,
        REGISTRA_JOGADA = 4'd9,
        ACERTO          = 4'd10,
        ERRO            = 4'd11,
        TIMEOUT         = 4'd12,
        FIM_JOGO        = 4'd15
    } estado_t;

    estado_t             estado;
    logic [TW-1:0]       timer;
    logic [VW-1:0]       voltas;
    logic [N_BOTOES-1:0] botoes_ant;
    logic                jogada;
    logic                ultima;

    // A press only counts on a release-to-press edge, so held buttons wait
    assign jogada = (botoes != '0) && (botoes_ant == '0);
    assign ultima = (endereco == ULTIMA);

    // Button history for press-edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) botoes_ant <= '0;
        else        botoes_ant <= botoes;
    end

    // Game sequencing, timer, replay count and score
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= INICIAL;
            endereco   <= '0;
            pontos     <= '0;
            jogada_reg <= '0;
            voltas     <= '0;
            timer      <= '0;
        end else begin
            case (estado)
                INICIAL: begin
                    timer <= '0;
                    if (iniciar) estado <= INICIO_JOGO;
                end
                INICIO_JOGO: begin
                    endereco   <= '0;
                    pontos     <= '0;
                    jogada_reg <= '0;
                    voltas     <= '0;
                    timer      <= '0;
                    estado     <= MOSTRA_PERGUNTA;
                end
                PROXIMA_RODADA: begin
                    endereco <= endereco + AW'(1);
                    voltas   <= '0;
                    timer    <= '0;
                    estado   <= MOSTRA_PERGUNTA;
                end
                MOSTRA_PERGUNTA: begin
                    if (timer == FIM_MOST) begin
                        timer  <= '0;
                        estado <= ESPERA_JOGADA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ESPERA_JOGADA: begin
                    if (jogada) begin
                        timer  <= '0;
                        estado <= REGISTRA_JOGADA;
                    end else if (timer == FIM_RESP) begin
                        timer  <= '0;
                        estado <= TIMEOUT;
                    end else if (volta && (voltas < VOLT_MAX)) begin
                        voltas <= voltas + VW'(1);
                        timer  <= '0;
                        estado <= MOSTRA_PERGUNTA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                REGISTRA_JOGADA: begin
                    jogada_reg <= botoes;
                    estado     <= COMPARA_JOGADA;
                end
                COMPARA_JOGADA: begin
                    if ($onehot(jogada_reg) && (jogada_reg == resposta_certa))
                        estado <= ACERTO;
                    else
                        estado <= ERRO;
                end
                ACERTO: begin
                    if (pontos != PTS_MAX) pontos <= pontos + PW'(1);
                    estado <= ultima ? FIM_JOGO : PROXIMA_RODADA;
                end
                ERRO: begin
                    estado <= ultima ? FIM_JOGO : PROXIMA_RODADA;
                end
                TIMEOUT: begin
                    jogada_reg <= '0;
                    estado     <= ultima ? FIM_JOGO : PROXIMA_RODADA;
                end
                FIM_JOGO: begin
                    timer <= '0;
                    if (iniciar) estado <= INICIO_JOGO;
                end
                default: begin
                    timer  <= '0;
                    estado <= INICIAL;
                end
            endcase
        end
    end

    // Flags depend on the current state alone
    assign mostra_pergunta = (estado == MOSTRA_PERGUNTA);
    assign espera_jogada   = (estado == ESPERA_JOGADA);
    assign acertou         = (estado == ACERTO);
    assign errou           = (estado == ERRO) || (estado == TIMEOUT);
    assign timeout         = (estado == TIMEOUT);
    assign pronto          = (estado == FIM_JOGO);
    assign db_estado       = estado;

endmodule

// File: tb/tb_unidade_controle_quiz.sv
// Self-checking bench for unidade_controle_quiz: scoreboard of
// expected outcomes, checked when the pulse outputs fire.
module tb_unidade_controle_quiz;

    localparam int TR = 500;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       volta = 1'b0;
    logic [3:0] botoes = 4'b0;
    logic [3:0] resposta_certa;
    logic [2:0] endereco;
    logic       mostra_pergunta, espera_jogada;
    logic       acertou, errou, timeout, pronto;
    logic [3:0] pontos;
    logic [3:0] jogada_reg;
    logic [3:0] db_estado;

    logic [3:0] mem [8];

    typedef struct packed {
        logic [2:0] flags;
        logic [2:0] q;
    } ev_t;

    localparam logic [2:0] F_AC = 3'b100;
    localparam logic [2:0] F_ER = 3'b010;
    localparam logic [2:0] F_TO = 3'b011;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_acertos = 0;

    unidade_controle_quiz dut (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .botoes          (botoes),
        .resposta_certa  (resposta_certa),
        .volta           (volta),
        .endereco        (endereco),
        .mostra_pergunta (mostra_pergunta),
        .espera_jogada   (espera_jogada),
        .acertou         (acertou),
        .errou           (errou),
        .timeout         (timeout),
        .pontos          (pontos),
        .jogada_reg      (jogada_reg),
        .pronto          (pronto),
        .db_estado       (db_estado)
    );

    assign resposta_certa = mem[endereco];

    always #5 clock = ~clock;

    // Scoreboard: every outcome pulse must match the oldest expectation
    always @(negedge clock) begin
        ev_t e;
        if (acertou) n_acertos++;
        if (acertou || errou || timeout) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL outcome_unexpected got=%b q=%0d",
                         {acertou, errou, timeout}, endereco);
            end else begin
                e = sb.pop_front();
                if ({acertou, errou, timeout} !== e.flags || endereco !== e.q) begin
                    n_err++;
                    $display("FAIL outcome got=%b q=%0d expected=%b q=%0d",
                             {acertou, errou, timeout}, endereco, e.flags, e.q);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_state(input logic [3:0] s, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (db_estado == s) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL wait_state got=%0d expected=%0d", db_estado, s);
        end
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        wait_state(4'd7, 400);
        botoes = b;
        @(negedge clock);
        @(negedge clock);
        botoes = 4'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (db_estado !== 4'd0) begin
            n_err++;
            $display("FAIL reset_state got=%0d expected=0", db_estado);
        end
        n_cmp++;
        if ({mostra_pergunta, espera_jogada, acertou, errou, timeout, pronto} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags got=%b expected=000000",
                     {mostra_pergunta, espera_jogada, acertou, errou, timeout, pronto});
        end
        n_cmp++;
        if ({endereco, pontos, jogada_reg} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_regs got=%h expected=0", {endereco, pontos, jogada_reg});
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if (db_estado !== 4'd0) begin
            n_err++;
            $display("FAIL idle_no_iniciar got=%0d expected=0", db_estado);
        end
    endtask

    task automatic test_all_correct();
        for (int i = 0; i < 8; i++) mem[i] = 4'(1 << (i % 4));
        n_acertos = 0;
        pulse_iniciar();
        for (int q = 0; q < 8; q++) begin
            sb.push_back(ev_t'({F_AC, 3'(q)}));
            press(mem[q]);
        end
        wait_state(4'd15, 50);
        n_cmp++;
        if (pronto !== 1'b1 || pontos !== 4'd8 || endereco !== 3'd7) begin
            n_err++;
            $display("FAIL all_correct_end got=%b/%0d/%0d expected=1/8/7",
                     pronto, pontos, endereco);
        end
        n_cmp++;
        if (n_acertos !== 8) begin
            n_err++;
            $display("FAIL acertou_count got=%0d expected=8", n_acertos);
        end
        n_cmp++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL sb_left_game1 got=%0d expected=0", sb.size());
        end
    endtask

    task automatic test_timeout();
        int k;
        for (int i = 0; i < 8; i++) mem[i] = 4'b0001;
        mem[2] = 4'b0100;
        mem[3] = 4'b0010;
        mem[4] = 4'b1000;
        pulse_iniciar();
        wait_state(4'd7, 400);
        sb.push_back(ev_t'({F_TO, 3'd0}));
        k = 0;
        while (!timeout && k < 1000) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (k !== TR || errou !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_latency got=%0d errou=%b expected=%0d errou=1",
                     k, errou, TR);
        end
        wait_state(4'd7, 400);
        n_cmp++;
        if (endereco !== 3'd1 || pontos !== 4'd0 || jogada_reg !== 4'd0) begin
            n_err++;
            $display("FAIL after_timeout got=%0d/%0d/%b expected=1/0/0000",
                     endereco, pontos, jogada_reg);
        end
    endtask

    task automatic test_volta();
        for (int r = 0; r < 2; r++) begin
            volta = 1'b1;
            @(negedge clock);
            volta = 1'b0;
            n_cmp++;
            if (db_estado !== 4'd4 || mostra_pergunta !== 1'b1) begin
                n_err++;
                $display("FAIL volta_%0d got=%0d expected=4", r, db_estado);
            end
            wait_state(4'd7, 400);
        end
        volta = 1'b1;
        @(negedge clock);
        volta = 1'b0;
        n_cmp++;
        if (db_estado !== 4'd7) begin
            n_err++;
            $display("FAIL volta_ignored got=%0d expected=7", db_estado);
        end
    endtask

    task automatic test_multihot();
        sb.push_back(ev_t'({F_ER, 3'd1}));
        press(4'b0011);
        @(negedge clock);
        n_cmp++;
        if (jogada_reg !== 4'b0011 || pontos !== 4'd0) begin
            n_err++;
            $display("FAIL multihot got=%b/%0d expected=0011/0", jogada_reg, pontos);
        end
    endtask

    task automatic test_held();
        wait_state(4'd4, 50);
        botoes = mem[2];
        wait_state(4'd7, 200);
        repeat (5) @(negedge clock);
        n_cmp++;
        if (db_estado !== 4'd7) begin
            n_err++;
            $display("FAIL held_button got=%0d expected=7", db_estado);
        end
        botoes = 4'b0;
        repeat (2) @(negedge clock);
        sb.push_back(ev_t'({F_AC, 3'd2}));
        botoes = mem[2];
        volta = 1'b1;
        @(negedge clock);
        volta = 1'b0;
        n_cmp++;
        if (db_estado !== 4'd9) begin
            n_err++;
            $display("FAIL jogada_over_volta got=%0d expected=9", db_estado);
        end
        @(negedge clock);
        botoes = 4'b0;
        wait_state(4'd3, 20);
        n_cmp++;
        if (pontos !== 4'd1) begin
            n_err++;
            $display("FAIL held_score got=%0d expected=1", pontos);
        end
    endtask

    task automatic test_reset_mid();
        sb.push_back(ev_t'({F_AC, 3'd3}));
        press(mem[3]);
        sb.push_back(ev_t'({F_AC, 3'd4}));
        press(mem[4]);
        wait_state(4'd7, 400);
        n_cmp++;
        if (endereco !== 3'd5 || pontos !== 4'd3) begin
            n_err++;
            $display("FAIL before_reset got=%0d/%0d expected=5/3", endereco, pontos);
        end
        #3 reset = 1'b0;
        #1;
        n_cmp++;
        if (db_estado !== 4'd0 || endereco !== 3'd0 || pontos !== 4'd0
            || espera_jogada !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got=%0d/%0d/%0d expected=0/0/0",
                     db_estado, endereco, pontos);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (db_estado !== 4'd0) begin
            n_err++;
            $display("FAIL post_reset_idle got=%0d expected=0", db_estado);
        end
        pulse_iniciar();
        wait_state(4'd7, 400);
        n_cmp++;
        if (endereco !== 3'd0 || pontos !== 4'd0) begin
            n_err++;
            $display("FAIL new_game got=%0d/%0d expected=0/0", endereco, pontos);
        end
        sb.push_back(ev_t'({F_AC, 3'd0}));
        press(mem[0]);
        wait_state(4'd3, 20);
        n_cmp++;
        if (pontos !== 4'd1 || sb.size() !== 0) begin
            n_err++;
            $display("FAIL new_game_score got=%0d sb=%0d expected=1 sb=0",
                     pontos, sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'b0001;
        test_reset();
        test_all_correct();
        test_timeout();
        test_volta();
        test_multihot();
        test_held();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unidade_controle_quiz.md
UNIDADE_CONTROLE_QUIZ -- requirements
Module: unidade_controle_quiz

Interface
REQ-001 Parameter N_RODADAS, default 8, number of questions per game (range 2..64).
REQ-002 Parameter N_BOTOES, default 4, number of answer buttons (range 2..8).
REQ-003 Parameter T_MOSTRA, default 100, clock cycles a question is shown (at least 1).
REQ-004 Parameter T_RESPOSTA, default 500, clock cycles allowed for an answer (at least 1).
REQ-005 Parameter MAX_VOLTAS, default 2, replays allowed per question (0 = replay disabled).
REQ-006 clock  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 iniciar  input  1  start or restart request, level-sampled.
REQ-009 botoes  input  N_BOTOES  answer buttons, already debounced and synchronous.
REQ-010 resposta_certa  input  N_BOTOES  one-hot correct answer for the current question, from the question memory.
REQ-011 volta  input  1  request to replay the current question.
REQ-012 endereco  output  clog2(N_RODADAS)  current question index (round counter).
REQ-013 mostra_pergunta  output  1  high while the question is displayed.
REQ-014 espera_jogada  output  1  high while an answer is accepted.
REQ-015 acertou / errou / timeout  output  1 each  one-cycle pulses per question outcome.
REQ-016 pontos  output  clog2(N_RODADAS+1)  number of correct answers in the current game.
REQ-017 jogada_reg  output  N_BOTOES  registered answer of the last question.
REQ-018 pronto  output  1  high in FIM_JOGO.
REQ-019 db_estado  output  4  current state encoding.

Function
REQ-020 States and encodings SHALL be: INICIAL=0, INICIO_JOGO=1, PROXIMA_RODADA=3, MOSTRA_PERGUNTA=4, ESPERA_JOGADA=7, REGISTRA_JOGADA=9, COMPARA_JOGADA=8, ACERTO=10, ERRO=11, TIMEOUT=12, FIM_JOGO=15; any other value goes to INICIAL on the next cycle.
REQ-021 INICIAL -> INICIO_JOGO when iniciar=1; INICIO_JOGO SHALL clear endereco, pontos, jogada_reg, voltas and the timer, then go to MOSTRA_PERGUNTA.
REQ-022 MOSTRA_PERGUNTA: mostra_pergunta=1; the timer counts from 0; exit to ESPERA_JOGADA after exactly T_MOSTRA cycles in the state, with the timer cleared on exit.
REQ-023 ESPERA_JOGADA: espera_jogada=1; the timer counts from 0.
REQ-024 Jogada event SHALL be a transition of botoes from all-zero to nonzero (previous-cycle value registered internally); buttons already held on entry SHALL NOT count until released.
REQ-025 Priority in ESPERA_JOGADA, highest first: jogada -> REGISTRA_JOGADA; timer reaching T_RESPOSTA-1 -> TIMEOUT; volta=1 with voltas<MAX_VOLTAS -> MOSTRA_PERGUNTA, voltas+1, timer cleared; otherwise stay.
REQ-026 A volta request with voltas=MAX_VOLTAS SHALL be ignored.
REQ-027 REGISTRA_JOGADA SHALL latch botoes into jogada_reg, then go to COMPARA_JOGADA.
REQ-028 COMPARA_JOGADA: jogada_reg==resposta_certa -> ACERTO, else ERRO; a multi-hot jogada_reg is always wrong.
REQ-029 ACERTO pulses acertou and increments pontos (saturating at N_RODADAS); ERRO pulses errou; TIMEOUT pulses timeout and errou and sets jogada_reg=0.
REQ-030 ACERTO, ERRO and TIMEOUT SHALL go to FIM_JOGO if endereco==N_RODADAS-1, else to PROXIMA_RODADA.
REQ-031 PROXIMA_RODADA SHALL increment endereco, clear voltas and the timer, then go to MOSTRA_PERGUNTA.
REQ-032 FIM_JOGO: pronto=1; endereco, pontos and jogada_reg hold their values; iniciar=1 -> INICIO_JOGO (direct restart).
REQ-033 iniciar SHALL be ignored in all states except INICIAL and FIM_JOGO.
REQ-034 The timer SHALL be wide enough for max(T_MOSTRA,T_RESPOSTA) and SHALL never wrap.
REQ-035 All outputs other than endereco, pontos, jogada_reg and db_estado SHALL be decoded from the state only (Moore).

Reset
REQ-036 When reset=0 at any time, including mid-game: state=INICIAL; endereco, pontos, jogada_reg, voltas, timer and the button-history register are cleared; all pulse and flag outputs are 0; db_estado=0.
REQ-037 After reset is released, the first transition SHALL occur on the first rising edge of clock with reset=1.

Verification
REQ-038 Defaults; iniciar, then answer every question correctly -> 8 acertou pulses, pontos=8, pronto=1, db_estado=15.
REQ-039 Question 0, no button press -> timeout and errou pulse exactly T_RESPOSTA cycles after entering ESPERA_JOGADA; endereco becomes 1; pontos=0.
REQ-040 volta pressed 3 times on one question, MAX_VOLTAS=2 -> two returns to MOSTRA_PERGUNTA (db_estado=4); the third is ignored (state stays 7).
REQ-041 botoes=4'b0011 with resposta_certa=4'b0001 -> errou pulse; jogada_reg=0011; pontos unchanged.
REQ-042 Button held across question entry -> no jogada until release and re-press; jogada and volta in the same cycle -> REGISTRA_JOGADA.
REQ-043 reset=0 asserted during question 5 -> asynchronous return to INICIAL with endereco=0 and pontos=0; a subsequent iniciar starts a new game from question 0.
